// File: rtl/rv32_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_lsu_if
//  Description : Data-memory bus between the load/store unit (master) and
//                data memory (slave): req/gnt request phase, rvalid response.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rv32_lsu_if #(
    parameter int XLEN = 32
) ();
    logic            req;
    logic            gnt;
    logic            we;
    logic [3:0]      be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface
`default_nettype wire

// File: rtl/rv32_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_lsu
//  Description : RV32I load/store unit sitting after the EX-stage ALU. Runs a
//                req/gnt/rvalid access to data memory, aligns store lanes,
//                extends load data and flags misaligned/illegal accesses.
//                Optional bus timeout enabled by macro LSU_BUS_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32_lsu #(
    parameter int XLEN           = 32,  // only 32 is supported
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            ex_valid_i,
    input  wire logic            ex_is_load_i,
    input  wire logic            ex_is_store_i,
    input  wire logic [2:0]      ex_funct3_i,
    input  wire logic [XLEN-1:0] ex_addr_i,
    input  wire logic [XLEN-1:0] ex_wdata_i,
    output logic                 lsu_busy_o,
    output logic                 lsu_done_o,
    output logic [XLEN-1:0]      lsu_rdata_o,
    output logic                 lsu_fault_o,
    output logic                 lsu_timeout_o,
    rv32_lsu_if.master           dmem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            is_load_q, is_load_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      lsb_q, lsb_d;
    logic            fault_q, fault_d;
    logic            timeout_q, timeout_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic            w_accept;
    logic            w_legal;
    logic            w_f3_ok;
    logic            w_align_ok;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_load;
    logic            w_to_hit;

    assign w_accept = (state_q == IDLE) && ex_valid_i && (ex_is_load_i || ex_is_store_i);

    // Legality of the op presented in IDLE: exactly one of load/store, valid funct3, natural alignment
    always_comb begin
        w_f3_ok    = 1'b0;
        w_align_ok = 1'b1;
        if (ex_is_load_i) begin
            w_f3_ok = ex_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end else begin
            w_f3_ok = !ex_funct3_i[2] && (ex_funct3_i[1:0] != 2'b11);
        end
        case (ex_funct3_i[1:0])
            2'b01:   w_align_ok = !ex_addr_i[0];
            2'b10:   w_align_ok = (ex_addr_i[1:0] == 2'b00);
            default: w_align_ok = 1'b1;
        endcase
        w_legal = (ex_is_load_i ^ ex_is_store_i) && w_f3_ok && w_align_ok;
    end

    // Byte-lane enables and lane-replicated store data for the incoming op
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = ex_wdata_i;
        case (ex_funct3_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << ex_addr_i[1:0];
                w_wdata = {4{ex_wdata_i[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << ex_addr_i[1:0];
                w_wdata = {2{ex_wdata_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = ex_wdata_i;
            end
        endcase
    end

    assign w_shifted = dmem.rdata >> {lsb_q, 3'b000};

    // Sign/zero extension of the addressed byte or halfword of the read word
    always_comb begin
        w_load = w_shifted;
        case (funct3_q)
            3'b000:  w_load = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
            3'b101:  w_load = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;

    // Cycles spent in REQ+WAIT; cleared while idle so it starts at zero on entry to REQ
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else if ((state_q == REQ) || (state_q == WAIT)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign w_to_hit      = ((state_q == REQ) || (state_q == WAIT)) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign lsu_timeout_o = lsu_done_o && timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^{timeout_q, 32'(TIMEOUT_CYCLES)};
    assign w_to_hit       = 1'b0;
    assign lsu_timeout_o  = 1'b0;
`endif

    // Next-state and next-register values for the access sequencer
    always_comb begin
        state_d   = state_q;
        is_load_d = is_load_q;
        funct3_d  = funct3_q;
        lsb_d     = lsb_q;
        fault_d   = fault_q;
        timeout_d = timeout_q;
        rdata_d   = rdata_q;
        req_d     = req_q;
        we_d      = we_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    is_load_d = ex_is_load_i;
                    funct3_d  = ex_funct3_i;
                    lsb_d     = ex_addr_i[1:0];
                    rdata_d   = '0;
                    timeout_d = 1'b0;
                    if (w_legal) begin
                        state_d = REQ;
                        fault_d = 1'b0;
                        req_d   = 1'b1;
                        we_d    = ex_is_store_i;
                        be_d    = w_be;
                        addr_d  = {ex_addr_i[XLEN-1:2], 2'b00};
                        wdata_d = ex_is_store_i ? w_wdata : '0;
                    end else begin
                        // Faulting ops never touch the bus
                        state_d = RESP;
                        fault_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (w_to_hit) begin
                    state_d   = RESP;
                    req_d     = 1'b0;
                    fault_d   = 1'b1;
                    timeout_d = 1'b1;
                end else if (dmem.gnt) begin
                    state_d = WAIT;
                    req_d   = 1'b0;
                end
            end
            WAIT: begin
                if (w_to_hit) begin
                    state_d   = RESP;
                    fault_d   = 1'b1;
                    timeout_d = 1'b1;
                end else if (dmem.rvalid) begin
                    state_d = RESP;
                    rdata_d = is_load_q ? w_load : '0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            is_load_q <= 1'b0;
            funct3_q  <= 3'b000;
            lsb_q     <= 2'b00;
            fault_q   <= 1'b0;
            timeout_q <= 1'b0;
            rdata_q   <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= 4'b0000;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
            funct3_q  <= funct3_d;
            lsb_q     <= lsb_d;
            fault_q   <= fault_d;
            timeout_q <= timeout_d;
            rdata_q   <= rdata_d;
            req_q     <= req_d;
            we_q      <= we_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.be    = be_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;

    // Busy drops in RESP so the pipeline advances on the done cycle
    assign lsu_busy_o  = w_accept || (state_q == REQ) || (state_q == WAIT);
    assign lsu_done_o  = (state_q == RESP);
    assign lsu_rdata_o = lsu_done_o ? rdata_q : '0;
    assign lsu_fault_o = lsu_done_o && fault_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32_lsu
//  Description : Scoreboard bench for rv32_lsu. Stimulus pushes the expected
//                completion into a queue; a monitor pops it on lsu_done.
//                Timeout scenario is active when LSU_BUS_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_lsu;
    localparam int XLEN = 32;
    localparam int TO   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            ex_valid    = 1'b0;
    logic            ex_is_load  = 1'b0;
    logic            ex_is_store = 1'b0;
    logic [2:0]      ex_funct3   = 3'b000;
    logic [XLEN-1:0] ex_addr     = '0;
    logic [XLEN-1:0] ex_wdata    = '0;
    logic            lsu_busy;
    logic            lsu_done;
    logic [XLEN-1:0] lsu_rdata;
    logic            lsu_fault;
    logic            lsu_timeout;

    rv32_lsu_if #(.XLEN(XLEN)) dmem_bus ();

    rv32_lsu #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid_i    (ex_valid),
        .ex_is_load_i  (ex_is_load),
        .ex_is_store_i (ex_is_store),
        .ex_funct3_i   (ex_funct3),
        .ex_addr_i     (ex_addr),
        .ex_wdata_i    (ex_wdata),
        .lsu_busy_o    (lsu_busy),
        .lsu_done_o    (lsu_done),
        .lsu_rdata_o   (lsu_rdata),
        .lsu_fault_o   (lsu_fault),
        .lsu_timeout_o (lsu_timeout),
        .dmem          (dmem_bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic        timeout;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        ex_valid    = 1'b1;
        ex_is_load  = ld;
        ex_is_store = st;
        ex_funct3   = f3;
        ex_addr     = a;
        ex_wdata    = wd;
    endtask

    task automatic release_ex();
        ex_valid    = 1'b0;
        ex_is_load  = 1'b0;
        ex_is_store = 1'b0;
    endtask

    // One complete access: accept, optional grant stall, response, done pulse
    task automatic do_access(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] resp,
                             input int gdly, input logic efault, input logic ewe, input logic [3:0] ebe,
                             input logic [31:0] eaddr, input logic [31:0] ewdata, input logic [31:0] erdata);
        exp_t e;
        e.rdata   = erdata;
        e.fault   = efault;
        e.timeout = 1'b0;
        exp_q.push_back(e);
        present(ld, st, f3, a, wd);
        #1;
        check1({nm, "_busy_accept"}, lsu_busy, 1'b1);
        tick();
        release_ex();
        if (efault) begin
            check1({nm, "_fault_done"}, lsu_done, 1'b1);
            check1({nm, "_fault_busy"}, lsu_busy, 1'b0);
            check1({nm, "_fault_noreq"}, dmem_bus.req, 1'b0);
            tick();
            check1({nm, "_done_once"}, lsu_done, 1'b0);
        end else begin
            check1({nm, "_req"}, dmem_bus.req, 1'b1);
            check1({nm, "_we"}, dmem_bus.we, ewe);
            check32({nm, "_be"}, {28'd0, dmem_bus.be}, {28'd0, ebe});
            check32({nm, "_addr"}, dmem_bus.addr, eaddr);
            check32({nm, "_wdata"}, dmem_bus.wdata, ewdata);
            for (int i = 0; i < gdly; i++) begin
                tick();
                check1({nm, "_stall_req"}, dmem_bus.req, 1'b1);
                check1({nm, "_stall_we"}, dmem_bus.we, ewe);
                check32({nm, "_stall_be"}, {28'd0, dmem_bus.be}, {28'd0, ebe});
                check32({nm, "_stall_addr"}, dmem_bus.addr, eaddr);
                check32({nm, "_stall_wdata"}, dmem_bus.wdata, ewdata);
                check1({nm, "_stall_busy"}, lsu_busy, 1'b1);
            end
            dmem_bus.gnt = 1'b1;
            tick();
            dmem_bus.gnt = 1'b0;
            check1({nm, "_req_drop"}, dmem_bus.req, 1'b0);
            check1({nm, "_wait_busy"}, lsu_busy, 1'b1);
            dmem_bus.rvalid = 1'b1;
            dmem_bus.rdata  = resp;
            tick();
            dmem_bus.rvalid = 1'b0;
            dmem_bus.rdata  = 32'h0;
            check1({nm, "_done"}, lsu_done, 1'b1);
            check1({nm, "_done_busy"}, lsu_busy, 1'b0);
            tick();
            check1({nm, "_done_once"}, lsu_done, 1'b0);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected completion
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (lsu_done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no completion (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check32("mon_rdata", lsu_rdata, e.rdata);
                    check1("mon_fault", lsu_fault, e.fault);
                    check1("mon_timeout", lsu_timeout, e.timeout);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        dmem_bus.gnt    = 1'b0;
        dmem_bus.rvalid = 1'b0;
        dmem_bus.rdata  = 32'h0;
        rst_n           = 1'b0;
        repeat (3) tick();
        check1("rst_req", dmem_bus.req, 1'b0);
        check1("rst_we", dmem_bus.we, 1'b0);
        check32("rst_be", {28'd0, dmem_bus.be}, 32'd0);
        check32("rst_addr", dmem_bus.addr, 32'h0);
        check1("rst_done", lsu_done, 1'b0);
        check1("rst_busy", lsu_busy, 1'b0);
        check1("rst_fault", lsu_fault, 1'b0);
        rst_n = 1'b1;
        tick();

        //          name     ld    st    f3      addr         wdata         resp          gd efault we    be       eaddr        ewdata        erdata
        do_access("lw",    1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1'b0, 1'b0, 4'b1111, 32'h100, 32'h0,        32'hDEADBEEF);
        do_access("lb",    1'b1, 1'b0, 3'b000, 32'h203, 32'h0,        32'h80FF1234, 0, 1'b0, 1'b0, 4'b1000, 32'h200, 32'h0,        32'hFFFFFF80);
        do_access("lbu",   1'b1, 1'b0, 3'b100, 32'h203, 32'h0,        32'h80FF1234, 0, 1'b0, 1'b0, 4'b1000, 32'h200, 32'h0,        32'h00000080);
        do_access("lh",    1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80011234, 0, 1'b0, 1'b0, 4'b1100, 32'h100, 32'h0,        32'hFFFF8001);
        do_access("lhu",   1'b1, 1'b0, 3'b101, 32'h102, 32'h0,        32'h80011234, 0, 1'b0, 1'b0, 4'b1100, 32'h100, 32'h0,        32'h00008001);
        do_access("sh",    1'b0, 1'b1, 3'b001, 32'h32,  32'h0000ABCD, 32'h12345678, 0, 1'b0, 1'b1, 4'b1100, 32'h30,  32'hABCDABCD, 32'h0);
        do_access("sb",    1'b0, 1'b1, 3'b000, 32'h01,  32'h776655A5, 32'h0,        0, 1'b0, 1'b1, 4'b0010, 32'h00,  32'hA5A5A5A5, 32'h0);
        do_access("sw_st", 1'b0, 1'b1, 3'b010, 32'h44,  32'h12345678, 32'h0,        5, 1'b0, 1'b1, 4'b1111, 32'h44,  32'h12345678, 32'h0);
        do_access("lw_mis",1'b1, 1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 1'b1, 1'b0, 4'b0000, 32'h0,   32'h0,        32'h0);
        do_access("lh_mis",1'b1, 1'b0, 3'b001, 32'h1,   32'h0,        32'h0,        0, 1'b1, 1'b0, 4'b0000, 32'h0,   32'h0,        32'h0);
        do_access("ld_011",1'b1, 1'b0, 3'b011, 32'h0,   32'h0,        32'h0,        0, 1'b1, 1'b0, 4'b0000, 32'h0,   32'h0,        32'h0);
        do_access("st_100",1'b0, 1'b1, 3'b100, 32'h0,   32'h0,        32'h0,        0, 1'b1, 1'b0, 4'b0000, 32'h0,   32'h0,        32'h0);
        do_access("both",  1'b1, 1'b1, 3'b010, 32'h0,   32'h0,        32'h0,        0, 1'b1, 1'b0, 4'b0000, 32'h0,   32'h0,        32'h0);

        // ex_valid with neither flag is ignored
        present(1'b0, 1'b0, 3'b010, 32'h100, 32'h0);
        #1;
        check1("noop_busy", lsu_busy, 1'b0);
        tick();
        release_ex();
        check1("noop_req", dmem_bus.req, 1'b0);
        check1("noop_done", lsu_done, 1'b0);

        // Reset during WAIT: back to idle, late rvalid must not complete
        present(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        tick();
        release_ex();
        dmem_bus.gnt = 1'b1;
        tick();
        dmem_bus.gnt = 1'b0;
        check1("rstw_in_wait", lsu_busy, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check1("rstw_busy", lsu_busy, 1'b0);
        check1("rstw_req", dmem_bus.req, 1'b0);
        check1("rstw_done", lsu_done, 1'b0);
        dmem_bus.rvalid = 1'b1;
        dmem_bus.rdata  = 32'hCAFEF00D;
        tick();
        dmem_bus.rvalid = 1'b0;
        check1("rstw_late_done", lsu_done, 1'b0);
        tick();
        check1("rstw_late_done2", lsu_done, 1'b0);

`ifdef LSU_BUS_TIMEOUT_EN
        begin
            exp_t e;
            int   n;
            e.rdata   = 32'h0;
            e.fault   = 1'b1;
            e.timeout = 1'b1;
            exp_q.push_back(e);
            present(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
            tick();
            release_ex();
            n = 0;
            while (dmem_bus.req && n < 100) begin
                n++;
                tick();
            end
            check32("to_req_cycles", n, TO);
            check1("to_req_low", dmem_bus.req, 1'b0);
            check1("to_done", lsu_done, 1'b1);
            dmem_bus.rvalid = 1'b1;
            tick();
            dmem_bus.rvalid = 1'b0;
            check1("to_late_done", lsu_done, 1'b0);
        end
`endif

        repeat (3) tick();
        check32("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
